// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N one-hot decoder with enable, direct decode, continuous
// scan and single-sweep sequencing modes, each output held for DWELL cycles.
module decoder_scan_n #(
  parameter int SEL_W      = 2,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    start,
  output logic [(2**SEL_W)-1:0]   y,
  output logic [SEL_W-1:0]        idx,
  output logic                    step,
  output logic                    wrap,
  output logic                    busy,
  output logic                    done
);

  localparam int OUT_W = 2 ** SEL_W;
  localparam int DCW   = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [DCW-1:0]   DLAST    = DCW'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);
  localparam logic [OUT_W-1:0] Y_OFF    = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  localparam logic [1:0] MODE_SCAN  = 2'b01;
  localparam logic [1:0] MODE_SWEEP = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN,
    SWEEP
  } state_t;

  state_t            state;
  logic [DCW-1:0]    dcnt;
  logic              slot_end;
  logic              last_slot;
  logic [SEL_W-1:0]  idx_next;

  // Code k lights y[OUT_W-1-k] (MSB-first); polarity applied here only.
  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] k);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int i = 0; i < OUT_W; i++) begin
      v[OUT_W-1-i] = (k == SEL_W'(i));
    end
    return ACTIVE_LOW ? ~v : v;
  endfunction

  assign slot_end  = (dcnt == DLAST);
  assign last_slot = slot_end && (idx == IDX_LAST);
  assign idx_next  = idx + SEL_W'(1);

  // One registered FSM; every output is a flop, so no input reaches y combinationally.
  // A mode change while sequencing falls into the "not already in this state"
  // branch, which is exactly the from-IDLE behaviour an abort requires.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      y     <= Y_OFF;
      idx   <= '0;
      dcnt  <= '0;
      step  <= 1'b0;
      wrap  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      done <= 1'b0;
      if (!en) begin
        state <= IDLE;
        y     <= Y_OFF;
        idx   <= '0;
        dcnt  <= '0;
        busy  <= 1'b0;
      end else begin
        case (mode)
          MODE_SCAN: begin
            busy <= 1'b1;
            if (state == SCAN) begin
              if (slot_end) begin
                dcnt <= '0;
                idx  <= idx_next;
                y    <= decode(idx_next);
                step <= 1'b1;
                wrap <= (idx == IDX_LAST);
              end else begin
                dcnt <= dcnt + DCW'(1);
              end
            end else begin
              state <= SCAN;
              idx   <= '0;
              dcnt  <= '0;
              y     <= decode('0);
            end
          end
          MODE_SWEEP: begin
            if (state == SWEEP) begin
              if (last_slot) begin
                state <= IDLE;
                y     <= Y_OFF;
                idx   <= '0;
                dcnt  <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else if (slot_end) begin
                dcnt <= '0;
                idx  <= idx_next;
                y    <= decode(idx_next);
                step <= 1'b1;
              end else begin
                dcnt <= dcnt + DCW'(1);
              end
            end else if (start) begin
              state <= SWEEP;
              idx   <= '0;
              dcnt  <= '0;
              y     <= decode('0);
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              y     <= Y_OFF;
              idx   <= '0;
              dcnt  <= '0;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= DIRECT;
            y     <= decode(sel);
            idx   <= sel;
            dcnt  <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decoder_scan_n.sv
// Scoreboard bench for decoder_scan_n: two instances (4-output DWELL=3 active-high,
// 8-output DWELL=1 active-low) driven by directed vectors with hand-derived results.
module tb_decoder_scan_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, start_a;
  logic [1:0] mode_a, sel_a;
  logic [3:0] y_a;
  logic [1:0] idx_a;
  logic       step_a, wrap_a, busy_a, done_a;

  logic       rst_b, en_b, start_b;
  logic [1:0] mode_b;
  logic [2:0] sel_b;
  logic [7:0] y_b;
  logic [2:0] idx_b;
  logic       step_b, wrap_b, busy_b, done_b;

  decoder_scan_n #(.SEL_W(2), .DWELL(3), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .sel(sel_a), .start(start_a),
    .y(y_a), .idx(idx_a), .step(step_a), .wrap(wrap_a), .busy(busy_a), .done(done_a)
  );

  decoder_scan_n #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .sel(sel_b), .start(start_b),
    .y(y_b), .idx(idx_b), .step(step_b), .wrap(wrap_b), .busy(busy_b), .done(done_b)
  );

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] idx;
    logic       step;
    logic       wrap;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t  qa[$];
  exp_t  qb[$];
  string na[$];
  string nb[$];
  int    errors = 0;
  int    checks = 0;

  function automatic exp_t mk(input logic [7:0] y, input logic [2:0] idx, input logic step,
                              input logic wrap, input logic busy, input logic done);
    exp_t e;
    e.y = y; e.idx = idx; e.step = step; e.wrap = wrap; e.busy = busy; e.done = done;
    return e;
  endfunction

  task automatic checkOutput(input string nm, input exp_t got, input exp_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got y=%b idx=%0d step=%b wrap=%b busy=%b done=%b, expected y=%b idx=%0d step=%b wrap=%b busy=%b done=%b",
               nm, got.y, got.idx, got.step, got.wrap, got.busy, got.done,
               exp.y, exp.idx, exp.step, exp.wrap, exp.busy, exp.done);
    end
  endtask

  // Inputs change on the falling edge; the matching expectation is queued for the next rising edge.
  task automatic applyStimulus(input bit which, input logic r, input logic e, input logic [1:0] m,
                               input logic [2:0] s, input logic st, input exp_t x, input string nm);
    @(negedge clk);
    if (which == 1'b0) begin
      rst_a = r; en_a = e; mode_a = m; sel_a = s[1:0]; start_a = st;
      qa.push_back(x); na.push_back(nm);
    end else begin
      rst_b = r; en_b = e; mode_b = m; sel_b = s; start_b = st;
      qb.push_back(x); nb.push_back(nm);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (qa.size() > 0)
      checkOutput(na.pop_front(), mk({4'b0000, y_a}, {1'b0, idx_a}, step_a, wrap_a, busy_a, done_a), qa.pop_front());
    if (qb.size() > 0)
      checkOutput(nb.pop_front(), mk(y_b, idx_b, step_b, wrap_b, busy_b, done_b), qb.pop_front());
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] dy [4] = '{8'b0000_1000, 8'b0000_0100, 8'b0000_0010, 8'b0000_0001};
    logic [7:0] yb;
    int         k;

    rst_a = 1'b1; en_a = 1'b0; mode_a = 2'b00; sel_a = 2'd0; start_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0; mode_b = 2'b00; sel_b = 3'd0; start_b = 1'b0;

    // ---- instance A: 4 outputs, DWELL=3, active-high ----
    repeat (2) applyStimulus(0, 1, 0, 2'b00, 3'd0, 0, mk(8'h00, 0, 0, 0, 0, 0), "a_reset");
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 0, 2'b01, 3'(i), 1, mk(8'h00, 0, 0, 0, 0, 0), "a_en_low");

    foreach (dy[i]) applyStimulus(0, 0, 1, 2'b00, 3'(i), 0, mk(dy[i], 3'(i), 0, 0, 0, 0), "a_direct_00");
    foreach (dy[i]) applyStimulus(0, 0, 1, 2'b11, 3'(i), 0, mk(dy[i], 3'(i), 0, 0, 0, 0), "a_direct_11");

    for (int c = 0; c < 26; c++) begin
      k = (c / 3) % 4;
      applyStimulus(0, 0, 1, 2'b01, 3'd0, 0,
                    mk(dy[k], 3'(k), (c > 0) && (c % 3 == 0), (c > 0) && (c % 12 == 0), 1, 0), "a_scan");
    end
    applyStimulus(0, 0, 0, 2'b01, 3'd0, 0, mk(8'h00, 0, 0, 0, 0, 0), "a_scan_abort_en");

    applyStimulus(0, 0, 1, 2'b10, 3'd0, 0, mk(8'h00, 0, 0, 0, 0, 0), "a_sweep_nostart");
    for (int c = 0; c <= 12; c++) begin
      if (c < 12)
        applyStimulus(0, 0, 1, 2'b10, 3'd0, (c == 0) || (c == 5),
                      mk(dy[c / 3], 3'(c / 3), (c > 0) && (c % 3 == 0), 0, 1, 0), "a_sweep");
      else
        applyStimulus(0, 0, 1, 2'b10, 3'd0, 0, mk(8'h00, 0, 0, 0, 0, 1), "a_sweep_done");
    end
    repeat (2) applyStimulus(0, 0, 1, 2'b10, 3'd0, 0, mk(8'h00, 0, 0, 0, 0, 0), "a_after_sweep");

    for (int c = 0; c <= 14; c++) begin
      if (c < 12)
        applyStimulus(0, 0, 1, 2'b10, 3'd0, 1,
                      mk(dy[c / 3], 3'(c / 3), (c > 0) && (c % 3 == 0), 0, 1, 0), "a_sweep_held");
      else if (c == 12)
        applyStimulus(0, 0, 1, 2'b10, 3'd0, 1, mk(8'h00, 0, 0, 0, 0, 1), "a_sweep_held_done");
      else
        applyStimulus(0, 0, 1, 2'b10, 3'd0, 1, mk(dy[0], 0, 0, 0, 1, 0), "a_sweep_restart");
    end
    applyStimulus(0, 0, 1, 2'b00, 3'd2, 1, mk(8'b0000_0010, 3'd2, 0, 0, 0, 0), "a_sweep_abort_direct");
    applyStimulus(0, 0, 0, 2'b00, 3'd2, 0, mk(8'h00, 0, 0, 0, 0, 0), "a_final_idle");

    // ---- instance B: 8 outputs, DWELL=1, active-low ----
    applyStimulus(1, 1, 0, 2'b00, 3'd0, 0, mk(8'hFF, 0, 0, 0, 0, 0), "b_reset");
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, 0, 2'b00, 3'(i * 3), 0, mk(8'hFF, 0, 0, 0, 0, 0), "b_en_low");
    applyStimulus(1, 0, 1, 2'b00, 3'd5, 0, mk(8'b1111_1011, 3'd5, 0, 0, 0, 0), "b_direct");
    for (int c = 0; c < 20; c++) begin
      yb = ~(8'h80 >> (c % 8));
      applyStimulus(1, 0, 1, 2'b01, 3'd0, 0,
                    mk(yb, 3'(c % 8), c > 0, (c > 0) && (c % 8 == 0), 1, 0), "b_scan");
    end
    applyStimulus(1, 1, 1, 2'b01, 3'd0, 1, mk(8'hFF, 0, 0, 0, 0, 0), "b_rst_midscan");
    applyStimulus(1, 0, 0, 2'b01, 3'd0, 0, mk(8'hFF, 0, 0, 0, 0, 0), "b_final_idle");

    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d/%0d pending expectations, expected 0/0", qa.size(), qb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
